toggle_req_rx: RTL and testbench

TOGGLE_REQ_RX -- requirements
Module: toggle_req_rx

---
 rtl/toggle_req_rx.sv | 127 ++++++++++++
 tb/tb_toggle_req_rx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/toggle_req_rx.sv
// Receive side of a toggle request/acknowledge handshake: synchronizes the sender's
// request toggle, captures its payload and presents it downstream with valid/ready.
module toggle_req_rx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_tgl,
  input  logic [WIDTH-1:0] req_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             ack_tgl,
  output logic             busy,
  output logic             overrun,
  output logic [7:0]       xfer_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_prev_q, req_prev_d;
  logic [WIDTH-1:0]       out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   ack_q, ack_d;
  logic                   overrun_q, overrun_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   req_s;
  logic                   event_s;

  assign req_s   = sync_q[SYNC_STAGES-1];
  assign event_s = (req_s != req_prev_q);

  // Metastability chain; req_tgl is asynchronous to clk and used nowhere else.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_tgl};
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_prev_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ack_q       <= 1'b0;
      overrun_q   <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      req_prev_q  <= req_prev_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ack_q       <= ack_d;
      overrun_q   <= overrun_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state logic; a new event seen while busy is flagged but left pending.
  always_comb begin
    state_d     = state_q;
    req_prev_d  = req_prev_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ack_d       = ack_q;
    overrun_d   = overrun_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (event_s) begin
          state_d    = CAPTURE;
          req_prev_d = req_s;
        end else begin
          state_d = IDLE;
        end
      end
      CAPTURE: begin
        out_data_d  = req_data;
        out_valid_d = 1'b1;
        state_d     = HOLD;
        if (event_s) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
      end
      HOLD: begin
        if (event_s) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
        if (out_ready) begin
          out_valid_d = 1'b0;
          ack_d       = ~ack_q;
          cnt_d       = cnt_q + 8'd1;
          state_d     = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign ack_tgl   = ack_q;
  assign overrun   = overrun_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_toggle_req_rx.sv
// Directed bench for toggle_req_rx: a sender model pushes expected words into a
// queue, and a monitor pops and compares each word the DUT hands downstream.
module tb_toggle_req_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_tgl;
  logic [7:0] req_data;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       ack_tgl;
  logic       busy;
  logic       overrun;
  logic [7:0] xfer_cnt;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       exp_ack;
  logic [7:0] exp_cnt;
  logic [7:0] held;

  toggle_req_rx #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .req_tgl(req_tgl), .req_data(req_data),
    .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid),
    .ack_tgl(ack_tgl), .busy(busy), .overrun(overrun), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor: every accepted word must match the head of the queue.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {24'd0, out_data}, 32'hFFFF_FFFF);
      end else begin
        check("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic toggle(input logic [7:0] d);
    req_data = d;
    req_tgl  = ~req_tgl;
    exp_q.push_back(d);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  // Full transfer with out_ready already high; waits for the ack toggle.
  task automatic send(input logic [7:0] d);
    int n = 0;
    toggle(d);
    exp_ack = ~exp_ack;
    exp_cnt = exp_cnt + 8'd1;
    while (ack_tgl !== exp_ack && n < 30) begin
      tick();
      n++;
    end
    check("ack_tgl", {31'd0, ack_tgl}, {31'd0, exp_ack});
    check("xfer_cnt", {24'd0, xfer_cnt}, {24'd0, exp_cnt});
    tick();
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    req_tgl = 1'b0;
    exp_q.delete();
    exp_ack = 1'b0;
    exp_cnt = 8'd0;
    tick(2);
    rst = 1'b1;
    tick(2);
  endtask

  initial begin
    rst       = 1'b0;
    req_tgl   = 1'b1;
    req_data  = 8'h00;
    out_ready = 1'b1;
    exp_ack   = 1'b0;
    exp_cnt   = 8'd0;
    held      = 8'h00;

    // Reset with request high and downstream ready: everything stays zero.
    tick(3);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {24'd0, out_data}, 32'd0);
    check("rst_ack",       {31'd0, ack_tgl}, 32'd0);
    check("rst_busy",      {31'd0, busy}, 32'd0);
    check("rst_overrun",   {31'd0, overrun}, 32'd0);
    check("rst_cnt",       {24'd0, xfer_cnt}, 32'd0);
    req_tgl = 1'b0;
    rst     = 1'b1;
    tick(3);
    check("idle_ack", {31'd0, ack_tgl}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Single transfer with exact latency.
    toggle(8'hA5);
    tick(3);
    check("lat_edge3_valid", {31'd0, out_valid}, 32'd0);
    check("lat_edge3_busy", {31'd0, busy}, 32'd1);
    tick();
    check("lat_edge4_valid", {31'd0, out_valid}, 32'd1);
    check("lat_edge4_data", {24'd0, out_data}, 32'h0000_00A5);
    tick();
    check("single_ack", {31'd0, ack_tgl}, 32'd1);
    check("single_cnt", {24'd0, xfer_cnt}, 32'd1);
    check("single_valid_drop", {31'd0, out_valid}, 32'd0);
    exp_ack = 1'b1;
    exp_cnt = 8'd1;
    tick(2);

    // Backpressure: word and ack frozen while downstream stalls.
    out_ready = 1'b0;
    toggle(8'h3C);
    wait_valid();
    held = out_data;
    check("bp_data", {24'd0, held}, 32'h0000_003C);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_stable", {24'd0, out_data}, {24'd0, held});
      check("bp_ack", {31'd0, ack_tgl}, {31'd0, exp_ack});
    end
    out_ready = 1'b1;
    exp_ack   = ~exp_ack;
    exp_cnt   = exp_cnt + 8'd1;
    tick();
    check("bp_release_ack", {31'd0, ack_tgl}, {31'd0, exp_ack});
    check("bp_release_cnt", {24'd0, xfer_cnt}, {24'd0, exp_cnt});
    tick(4);
    check("bp_single_ack", {31'd0, ack_tgl}, {31'd0, exp_ack});

    // Overrun: double toggle during HOLD is lost but flagged.
    out_ready = 1'b0;
    toggle(8'h5A);
    wait_valid();
    check("ovr_before", {31'd0, overrun}, 32'd0);
    req_tgl = ~req_tgl;
    tick(3);
    req_tgl = ~req_tgl;
    tick(3);
    check("ovr_set", {31'd0, overrun}, 32'd1);
    check("ovr_still_hold", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    exp_ack   = ~exp_ack;
    exp_cnt   = exp_cnt + 8'd1;
    tick();
    check("ovr_cnt", {24'd0, xfer_cnt}, {24'd0, exp_cnt});
    tick(8);
    check("ovr_no_extra_cnt", {24'd0, xfer_cnt}, {24'd0, exp_cnt});
    check("ovr_no_extra_ack", {31'd0, ack_tgl}, {31'd0, exp_ack});
    check("ovr_idle", {31'd0, busy}, 32'd0);
    check("ovr_sticky", {31'd0, overrun}, 32'd1);
    do_reset();
    check("ovr_cleared", {31'd0, overrun}, 32'd0);
    check("ovr_rst_cnt", {24'd0, xfer_cnt}, 32'd0);

    // Reset while HOLD drops valid immediately.
    out_ready = 1'b0;
    toggle(8'hC3);
    wait_valid();
    rst = 1'b0;
    #1;
    check("rh_valid", {31'd0, out_valid}, 32'd0);
    check("rh_ack", {31'd0, ack_tgl}, 32'd0);
    check("rh_busy", {31'd0, busy}, 32'd0);
    check("rh_data", {24'd0, out_data}, 32'd0);
    req_tgl = 1'b0;
    exp_q.delete();
    exp_ack = 1'b0;
    exp_cnt = 8'd0;
    tick(2);
    rst = 1'b1;
    tick(4);
    check("rh_idle_after", {31'd0, busy}, 32'd0);
    check("rh_no_valid_after", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;

    // 256 transfers: in-order delivery, counter wrap, even ack parity.
    for (int i = 0; i < 256; i++) begin
      send(8'(i));
    end
    check("wrap_cnt", {24'd0, xfer_cnt}, 32'd0);
    check("wrap_ack", {31'd0, ack_tgl}, 32'd0);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
